// File: rtl/key_debounce_ctrl.sv
// key_debounce_ctrl: two-key synchroniser/debouncer feeding the servo PWM up/down inputs.
// Each key has a 2-flop synchroniser and a four-state debounce FSM with its own counter.
// The level and strobe registers update on the same edge as the FSM transition that accepts a change.
module key_debounce_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
  parameter logic        KEY_ACTIVE      = 1'b0,
  parameter int unsigned CNT_W           = 32
) (
  input  logic sclk,
  input  logic rst,
  input  logic key1_raw,
  input  logic key2_raw,
  output logic key1,
  output logic key2,
  output logic key1_press,
  output logic key2_press,
  output logic key_release
);

  localparam int unsigned NUM_KEYS = 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_WAIT,
    ST_HELD,
    ST_RELEASE_WAIT
  } state_e;

  logic [NUM_KEYS-1:0] raw;
  logic [NUM_KEYS-1:0] lvl;
  logic [NUM_KEYS-1:0] press;
  logic [NUM_KEYS-1:0] rel;

  assign raw = {key2_raw, key1_raw};

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    logic [1:0]       sync_q;
    logic             pressed;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             lvl_q;
    logic             press_q;
    logic             rel_q;

    // Two-flop synchroniser; reset loads the inactive pin level
    always_ff @(posedge sclk) begin
      if (rst) begin
        sync_q <= {2{~KEY_ACTIVE}};
      end else begin
        sync_q <= {sync_q[0], raw[g]};
      end
    end

    assign pressed = (sync_q[1] == KEY_ACTIVE);

    // Debounce FSM: a change is accepted only after DEBOUNCE_CYCLES stable samples
    always_ff @(posedge sclk) begin
      if (rst) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        lvl_q   <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        case (state_q)
          ST_IDLE: begin
            if (pressed) begin
              state_q <= ST_PRESS_WAIT;
              cnt_q   <= '0;
            end
          end
          ST_PRESS_WAIT: begin
            if (!pressed) begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_LAST) begin
              state_q <= ST_HELD;
              cnt_q   <= '0;
              lvl_q   <= 1'b1;
              press_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          ST_HELD: begin
            if (!pressed) begin
              state_q <= ST_RELEASE_WAIT;
              cnt_q   <= '0;
            end
          end
          ST_RELEASE_WAIT: begin
            if (pressed) begin
              state_q <= ST_HELD;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_LAST) begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
              lvl_q   <= 1'b0;
              rel_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
          end
        endcase
      end
    end

    assign lvl[g]   = lvl_q;
    assign press[g] = press_q;
    assign rel[g]   = rel_q;
  end

  // Interlock: holding both keys freezes the PWM width; strobes are not interlocked
  assign key1        = lvl[0] & ~lvl[1];
  assign key2        = lvl[1] & ~lvl[0];
  assign key1_press  = press[0];
  assign key2_press  = press[1];
  assign key_release = |rel;

endmodule
